axi4_slave_bresp_scheduler: RTL

Write-response scheduler for the AXI4 slave side of the VIP. It queues completed write transactions (ID + response code) reported by the slave driver BFM logic. After a programmable per-response delay, it issues them in order on the B channel with a standard valid/ready handshake. It sequences B-channel traffic so the driver proxy only reports completions and never times the handshake itself.

---
 rtl/axi4_slave_bresp_scheduler_if.sv | 32 +++
 rtl/axi4_slave_bresp_scheduler.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/axi4_slave_bresp_scheduler_if.sv
// +----------------------------------------------------------------------------+
// | Module      : axi4_slave_bresp_scheduler_if                                |
// | Description : Completion-report and B-channel signal bundle for the        |
// |               AXI4 slave write-response scheduler.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface axi4_slave_bresp_scheduler_if #(
  parameter int ID_WIDTH = 4
);
  logic                wr_done_valid;
  logic [ID_WIDTH-1:0] wr_done_id;
  logic [1:0]          wr_done_resp;
  logic                wr_done_ready;
  logic                bvalid;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic                bready;

  modport slave (
    input  wr_done_valid, wr_done_id, wr_done_resp, bready,
    output wr_done_ready, bvalid, bid, bresp
  );

  modport master (
    output wr_done_valid, wr_done_id, wr_done_resp, bready,
    input  wr_done_ready, bvalid, bid, bresp
  );
endinterface

`default_nettype wire

// File: rtl/axi4_slave_bresp_scheduler.sv
// +----------------------------------------------------------------------------+
// | Module      : axi4_slave_bresp_scheduler                                   |
// | Description : Queues completed writes and issues them in order on the B    |
// |               channel after a programmable delay. Optional macro           |
// |               SLAVE_BRESP_ERR_INJECT_EN adds err_inject (forces SLVERR).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module axi4_slave_bresp_scheduler #(
  parameter int ID_WIDTH    = 4,
  parameter int DEPTH       = 8,
  parameter int DELAY_WIDTH = 4
) (
  input  wire logic                         aclk,
  input  wire logic                         aresetn,
  input  wire logic [DELAY_WIDTH-1:0]       cfg_delay,
  output logic      [$clog2(DEPTH+1)-1:0]   pending_count,
`ifdef SLAVE_BRESP_ERR_INJECT_EN
  input  wire logic                         err_inject,
`endif
  axi4_slave_bresp_scheduler_if.slave       bus
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH + 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;

  logic [1:0]             r_state;
  logic [1:0]             w_state_next;
  logic [ID_WIDTH-1:0]    r_mem_id   [DEPTH];
  logic [1:0]             r_mem_resp [DEPTH];
  logic [c_AW-1:0]        r_wr_ptr;
  logic [c_AW-1:0]        r_rd_ptr;
  logic [c_CW-1:0]        r_count;
  logic [DELAY_WIDTH-1:0] r_delay_cnt;
  logic [ID_WIDTH-1:0]    r_bid;
  logic [1:0]             r_bresp;
  logic                   w_ready;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_bvalid;
  logic                   w_load_cnt;
  logic                   w_load_head;
  logic [1:0]             w_push_resp;
  logic [c_AW-1:0]        w_head_ptr;

  assign w_ready = (r_count != c_CW'(DEPTH));
  assign w_push  = bus.wr_done_valid && w_ready;

`ifdef SLAVE_BRESP_ERR_INJECT_EN
  assign w_push_resp = err_inject ? 2'b10 : bus.wr_done_resp;
`else
  assign w_push_resp = bus.wr_done_resp;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= c_IDLE;
    else          r_state <= w_state_next;
  end

  // "Another entry remains" is judged on the registered count, so a push that
  // coincides with the last pop is picked up from IDLE on the following cycle.
  always_comb begin
    w_state_next = r_state;
    w_load_cnt   = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (r_count != '0) begin
          if (cfg_delay == '0) begin
            w_state_next = c_RESP;
          end else begin
            w_state_next = c_WAIT;
            w_load_cnt   = 1'b1;
          end
        end
      end
      c_WAIT: begin
        if (r_delay_cnt <= DELAY_WIDTH'(1)) w_state_next = c_RESP;
      end
      c_RESP: begin
        if (bus.bready) begin
          if (r_count > c_CW'(1)) begin
            if (cfg_delay == '0) begin
              w_state_next = c_RESP;
            end else begin
              w_state_next = c_WAIT;
              w_load_cnt   = 1'b1;
            end
          end else begin
            w_state_next = c_IDLE;
          end
        end
      end
      default: w_state_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_bvalid    = (r_state == c_RESP);
    w_pop       = w_bvalid && bus.bready;
    w_load_head = (w_state_next == c_RESP) && ((r_state != c_RESP) || w_pop);
    w_head_ptr  = w_pop ? (r_rd_ptr + c_AW'(1)) : r_rd_ptr;
  end

  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_mem_id[r_wr_ptr]   <= bus.wr_done_id;
      r_mem_resp[r_wr_ptr] <= w_push_resp;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_delay_cnt <= '0;
      r_bid       <= '0;
      r_bresp     <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_load_cnt)
        r_delay_cnt <= cfg_delay;
      else if ((r_state == c_WAIT) && (r_delay_cnt != '0))
        r_delay_cnt <= r_delay_cnt - DELAY_WIDTH'(1);
      // Head is captured on entry to RESP and held through any stall.
      if (w_load_head) begin
        r_bid   <= r_mem_id[w_head_ptr];
        r_bresp <= r_mem_resp[w_head_ptr];
      end else if (w_state_next != c_RESP) begin
        r_bid   <= '0;
        r_bresp <= '0;
      end
    end
  end

  assign bus.wr_done_ready = w_ready;
  assign bus.bvalid        = w_bvalid;
  assign bus.bid           = r_bid;
  assign bus.bresp         = r_bresp;
  assign pending_count     = r_count;

endmodule

`default_nettype wire
